// File: rtl/hilo_mpy_ctrl.sv
// HI/LO back end for a combinational 32x32 multiplier: holds operands over a multicycle path,
// captures the product, serves MFHI/MFLO/MTHI/MTLO. Optional read bypass: HILO_BYPASS_EN.
module hilo_mpy_ctrl #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned CW      = 4,
    localparam int unsigned DW     = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] op_s,
    input  logic [DW-1:0] op_t,
    output logic [DW-1:0] mpy_s,
    output logic [DW-1:0] mpy_t,
    input  logic [DW-1:0] mpy_hi,
    input  logic [DW-1:0] mpy_lo,
    input  logic          mthi,
    input  logic          mtlo,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_sel,
    output logic [DW-1:0] rd_data,
    output logic          stall,
    output logic          busy,
    output logic          done,
    output logic          n_flag,
    output logic          z_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [DW-1:0] mpy_s_q, mpy_s_d;
    logic [DW-1:0] mpy_t_q, mpy_t_d;
    logic          done_q, done_d;
    logic          n_q, n_d;
    logic          z_q, z_d;
    logic          last_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mpy_s_q <= '0;
            mpy_t_q <= '0;
            done_q  <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mpy_s_q <= mpy_s_d;
            mpy_t_q <= mpy_t_d;
            done_q  <= done_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    // Next-state logic; start takes priority over a same-cycle MTHI/MTLO
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mpy_s_d = mpy_s_q;
        mpy_t_d = mpy_t_q;
        done_d  = 1'b0;
        n_d     = n_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mpy_s_d = op_s;
                    mpy_t_d = op_t;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end else begin
                    if (mthi) hi_d = wr_data;
                    if (mtlo) lo_d = wr_data;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    hi_d    = mpy_hi;
                    lo_d    = mpy_lo;
                    n_d     = mpy_hi[DW-1];
                    z_d     = ({mpy_hi, mpy_lo} == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == BUSY);
    assign last_c = busy && (cnt_q == '0);
    assign mpy_s  = mpy_s_q;
    assign mpy_t  = mpy_t_q;
    assign done   = done_q;
    assign n_flag = n_q;
    assign z_flag = z_q;

`ifdef HILO_BYPASS_EN
    // Forward the product in the capture cycle so a dependent read finishes a cycle early
    assign rd_data = last_c ? (rd_sel ? mpy_hi : mpy_lo) : (rd_sel ? hi_q : lo_q);
    assign stall   = rd_en && busy && !last_c;
`else
    assign rd_data = rd_sel ? hi_q : lo_q;
    assign stall   = rd_en && busy;
`endif

endmodule
